// File: rtl/recovery_pkg.sv
// Shared recovery definitions: packet-receiver FSM states, default length limit and the CRC8 step.
package recovery_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_PEC,
      ST_DONE,
      ST_DRAIN
   } rx_state_e;

   localparam logic [15:0] MAX_LEN_DEFAULT = 16'd255;
   localparam logic [7:0]  CRC8_POLY       = 8'h07;

   // One byte of MSB-first CRC8 (x^8+x^2+x+1), no reflection, no final xor.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/recovery_pec.sv
// CRC8 accumulator stage: init_i restarts the sum from zero on the byte presented with it.
module recovery_pec
   import recovery_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       init_i,
   input  logic       valid_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   logic [7:0] crc_q, crc_d;

   always_comb begin
      crc_d = crc_q;
      if (clr_i) begin
         crc_d = 8'h00;
      end else if (valid_i) begin
         crc_d = crc8_step(init_i ? 8'h00 : crc_q, data_i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         crc_q <= 8'h00;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/recovery_pkt_rx.sv
// Recovery packet receiver: CMD, LEN_LO, LEN_HI, payload, PEC framing with payload pass-through.
// Define RECOVERY_PKT_RX_PEC_CHECK_EN to build the CRC8 check of the PEC byte.
module recovery_pkt_rx
   import recovery_pkg::*;
#(
   parameter logic [15:0] MaxLen = MAX_LEN_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        soft_reset_ni,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_last_i,
   output logic [7:0]  cmd_o,
   output logic [15:0] len_o,
   output logic        cmd_valid_o,
   output logic        pl_valid_o,
   input  logic        pl_ready_i,
   output logic [7:0]  pl_data_o,
   output logic        pl_last_o,
   output logic        pkt_done_o,
   output logic        pec_ok_o,
   output logic        len_err_o
);

   rx_state_e   state_q, state_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [15:0] len_q, len_d;
   logic [15:0] cnt_q, cnt_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic        len_err_q, len_err_d;
   logic        rx_ready;
   logic        accept;
   logic [15:0] len_rx;

`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
   logic       pec_ok_q, pec_ok_d;
   logic       crc_init;
   logic       crc_fold;
   logic [7:0] crc;

   assign crc_init = accept && (state_q == ST_IDLE);
   assign crc_fold = accept && (state_q inside {ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA});

   recovery_pec u_pec (
      .clk_i   (clk_i),
      .rst_ni  (~rst_i),
      .clr_i   (~soft_reset_ni),
      .init_i  (crc_init),
      .valid_i (crc_fold),
      .data_i  (rx_data_i),
      .crc_o   (crc)
   );
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         cmd_q       <= 8'h00;
         len_q       <= 16'h0000;
         cnt_q       <= 16'h0000;
         cmd_valid_q <= 1'b0;
         len_err_q   <= 1'b0;
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
         pec_ok_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         cmd_valid_q <= cmd_valid_d;
         len_err_q   <= len_err_d;
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
         pec_ok_q    <= pec_ok_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      cmd_valid_d = cmd_valid_q;
      len_err_d   = len_err_q;
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
      pec_ok_d    = pec_ok_q;
`endif
      len_rx      = {rx_data_i, len_q[7:0]};
      unique case (state_q)
         ST_IDLE: if (accept) begin
            cmd_d       = rx_data_i;
            cmd_valid_d = 1'b0;
            len_err_d   = rx_last_i;
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
            pec_ok_d    = 1'b0;
`endif
            state_d     = rx_last_i ? ST_DONE : ST_LEN_LO;
         end
         ST_LEN_LO: if (accept) begin
            len_d     = {8'h00, rx_data_i};
            len_err_d = rx_last_i;
            state_d   = rx_last_i ? ST_DONE : ST_LEN_HI;
         end
         ST_LEN_HI: if (accept) begin
            len_d       = len_rx;
            cnt_d       = len_rx;
            cmd_valid_d = 1'b1;
            if (rx_last_i) begin
               len_err_d = 1'b1;
               state_d   = ST_DONE;
            end else if (len_rx > MaxLen) begin
               len_err_d = 1'b1;
               state_d   = ST_DRAIN;
            end else if (len_rx == 16'h0000) begin
               state_d = ST_PEC;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: if (accept) begin
            cnt_d = cnt_q - 16'd1;
            if (rx_last_i) begin
               len_err_d = 1'b1;
               state_d   = ST_DONE;
            end else if (cnt_q == 16'd1) begin
               state_d = ST_PEC;
            end
         end
         ST_PEC: if (accept) begin
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
            pec_ok_d = (rx_data_i == crc);
`endif
            if (!rx_last_i) begin
               len_err_d = 1'b1;
            end
            state_d = rx_last_i ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: if (accept && rx_last_i) begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            cmd_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Soft reset abandons the packet; it wins over every transition above.
      if (!soft_reset_ni) begin
         state_d     = ST_IDLE;
         cmd_d       = 8'h00;
         len_d       = 16'h0000;
         cnt_d       = 16'h0000;
         cmd_valid_d = 1'b0;
         len_err_d   = 1'b0;
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
         pec_ok_d    = 1'b0;
`endif
      end
   end

   always_comb begin
      rx_ready = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_PEC, ST_DRAIN: rx_ready = 1'b1;
         ST_DATA: rx_ready = pl_ready_i;
         default: rx_ready = 1'b0;
      endcase
      rx_ready_o  = rx_ready && !rst_i;
      accept      = rx_valid_i && rx_ready_o;
      pl_valid_o  = (state_q == ST_DATA) && rx_valid_i;
      pl_data_o   = (state_q == ST_DATA) ? rx_data_i : 8'h00;
      pl_last_o   = pl_valid_o && (cnt_q == 16'd1);
      pkt_done_o  = (state_q == ST_DONE);
      len_err_o   = pkt_done_o && len_err_q;
`ifdef RECOVERY_PKT_RX_PEC_CHECK_EN
      pec_ok_o    = pkt_done_o && pec_ok_q && !len_err_q;
`else
      pec_ok_o    = pkt_done_o && !len_err_q;
`endif
      cmd_o       = cmd_q;
      len_o       = len_q;
      cmd_valid_o = cmd_valid_q;
   end

endmodule
